// File: rtl/rsa_modexp_stream_if.sv
// Bundle of the control, memory and result-stream signals of the modular
// exponentiation engine.
//   master : host side. Drives exe, mode, n_mod, e_key, d_key and mem_data,
//            observes everything else.
//   slave  : engine side. Drives mem_rd, mem_addr, o_en, result, busy and
//            done.
interface rsa_modexp_stream_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 6
);
   logic             exe;
   logic             mode;
   logic [WIDTH-1:0] n_mod;
   logic [WIDTH-1:0] e_key;
   logic [WIDTH-1:0] d_key;
   logic             mem_rd;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_data;
   logic             o_en;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;

   modport master (
      output exe, mode, n_mod, e_key, d_key, mem_data,
      input  mem_rd, mem_addr, o_en, result, busy, done
   );

   modport slave (
      input  exe, mode, n_mod, e_key, d_key, mem_data,
      output mem_rd, mem_addr, o_en, result, busy, done
   );
endinterface

// File: rtl/rsa_modexp_stream.sv
// Streaming modular exponentiation engine.
// After exe is accepted it reads NWORDS words from a synchronous memory
// (one-cycle read latency) and for each word M emits M^X mod N, where X is
// e_key or d_key depending on mode sampled when the word is loaded.
// Exponentiation is left-to-right square-and-multiply over all WIDTH key bits
// (no leading-zero skip); every modular product is bit-serial interleaved,
// one multiplier bit per cycle, so each SQR/MUL step takes exactly WIDTH cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rsa_modexp_stream_if (control, memory, result)
module rsa_modexp_stream #(
   parameter int WIDTH  = 32,
   parameter int NWORDS = 64,
   parameter int AW     = 6
) (
   input logic                 clk,
   input logic                 rst_n,
   rsa_modexp_stream_if.slave  bus
);
   localparam int BW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SQR, MUL, OUT, DONE} state_t;

   state_t           st;
   logic [AW-1:0]    idx;     // current word index
   logic [BW-1:0]    bit_i;   // exponent bit being processed
   logic [BW-1:0]    cnt;     // multiplier bit of the running modmul
   logic [WIDTH-1:0] r_q;     // running exponentiation result
   logic [WIDTH-1:0] m_q;     // message word
   logic [WIDTH-1:0] x_q;     // exponent latched at LOAD
   logic [WIDTH-1:0] p_q;     // modmul partial product, always < N

   logic [WIDTH:0]   n_ext, b_ext, acc;
   logic [WIDTH-1:0] p_nxt;

   // One interleaved modmul iteration. R is always the multiplier A (its bits
   // are scanned MSB first by cnt); the addend is R when squaring, M when
   // multiplying. One extra bit holds 2P and P+B, both below 2N.
   always_comb begin
      n_ext = {1'b0, bus.n_mod};
      b_ext = (st == MUL) ? {1'b0, m_q} : {1'b0, r_q};
      acc   = {p_q, 1'b0};
      if (acc >= n_ext) acc = acc - n_ext;
      if (r_q[cnt]) begin
         acc = acc + b_ext;
         if (acc >= n_ext) acc = acc - n_ext;
      end
      p_nxt = acc[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= IDLE;
         idx          <= '0;
         bit_i        <= '0;
         cnt          <= '0;
         r_q          <= '0;
         m_q          <= '0;
         x_q          <= '0;
         p_q          <= '0;
         bus.mem_rd   <= 1'b0;
         bus.mem_addr <= '0;
         bus.o_en     <= 1'b0;
         bus.result   <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (bus.exe) begin
                  st           <= FETCH;
                  idx          <= '0;
                  bus.mem_addr <= '0;
                  bus.mem_rd   <= 1'b1;
                  bus.busy     <= 1'b1;
               end
            end
            FETCH: begin
               bus.mem_rd <= 1'b0;
               st         <= LOAD;
            end
            LOAD: begin
               // Key and mode are frozen here for the whole word.
               m_q   <= bus.mem_data;
               x_q   <= bus.mode ? bus.d_key : bus.e_key;
               r_q   <= WIDTH'(1);
               bit_i <= BW'(WIDTH-1);
               cnt   <= BW'(WIDTH-1);
               p_q   <= '0;
               st    <= SQR;
            end
            SQR: begin
               p_q <= p_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  r_q <= p_nxt;
                  p_q <= '0;
                  cnt <= BW'(WIDTH-1);
                  if (x_q[bit_i]) begin
                     st <= MUL;
                  end else if (bit_i == '0) begin
                     st         <= OUT;
                     bus.result <= p_nxt;
                     bus.o_en   <= 1'b1;
                  end else begin
                     bit_i <= bit_i - 1'b1;
                  end
               end
            end
            MUL: begin
               p_q <= p_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  r_q <= p_nxt;
                  p_q <= '0;
                  cnt <= BW'(WIDTH-1);
                  if (bit_i == '0) begin
                     st         <= OUT;
                     bus.result <= p_nxt;
                     bus.o_en   <= 1'b1;
                  end else begin
                     bit_i <= bit_i - 1'b1;
                     st    <= SQR;
                  end
               end
            end
            OUT: begin
               bus.o_en <= 1'b0;
               if (idx == AW'(NWORDS-1)) begin
                  st       <= DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  idx          <= idx + 1'b1;
                  bus.mem_addr <= idx + 1'b1;
                  bus.mem_rd   <= 1'b1;
                  st           <= FETCH;
               end
            end
            DONE: begin
               // Wait for exe to drop so a held request does not rerun.
               if (!bus.exe) begin
                  st       <= IDLE;
                  bus.done <= 1'b0;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rsa_modexp_stream.sv
module tb_rsa_modexp_stream;
   localparam int W  = 16;
   localparam int NW = 64;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   rsa_modexp_stream_if #(.WIDTH(W), .AW(AW)) bus ();
   rsa_modexp_stream #(.WIDTH(W), .NWORDS(NW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // synchronous message memory, one cycle read latency
   logic [W-1:0] mem [NW];
   always @(posedge clk or negedge rst_n)
      if (!rst_n) bus.mem_data <= '0;
      else if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

   int checks = 0, errors = 0;

   // stream consumer / monitor, sampled on the falling edge
   int cyc = 0, npulse = 0, t_fetch = 0, last_lat = 0, wide_err = 0, hold_err = 0;
   logic prev_oen = 1'b0;
   logic [W-1:0] held = '0;
   int unsigned cap_q[$];
   always @(negedge clk) begin
      cyc++;
      if (bus.mem_rd) t_fetch = cyc;
      if (bus.o_en) begin
         npulse++;
         last_lat = cyc - t_fetch;
         cap_q.push_back(bus.result);
         if (prev_oen) wide_err++;
      end
      if (!rst_n) held = '0;
      else if (bus.o_en) held = bus.result;
      else if (bus.result != held) hold_err++;
      prev_oen = bus.o_en;
   end

   // reference: right-to-left binary exponentiation with plain arithmetic
   function automatic longint modexp(longint m, longint x, longint n);
      longint r = 1 % n;
      longint b = m % n;
      while (x > 0) begin
         if ((x & 1) != 0) r = (r * b) % n;
         b = (b * b) % n;
         x = x >> 1;
      end
      return r;
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic timeout(string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic wait_pulses(int target, string nm);
      int budget = (target - npulse) * 700 + 100;
      while (npulse < target && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
      if (npulse < target) timeout(nm);
   endtask

   task automatic wait_fetch(string nm);
      int budget = 800;
      do begin
         @(negedge clk); #1;
         budget--;
      end while (!bus.mem_rd && budget > 0);
      if (!bus.mem_rd) timeout(nm);
   endtask

   task automatic do_reset();
      @(negedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
   endtask

   function automatic longint outs();
      return {bus.mem_rd, bus.mem_addr, bus.o_en, bus.result, bus.busy, bus.done};
   endfunction

   typedef struct {
      logic mode;
      int   n, e, d, m, exp;
   } vec_t;
   vec_t tv[7];

   initial begin
      int base, n, e, d;
      logic md;
      tv[0] = '{1'b0, 3233, 17,   0,    65,   2790};
      tv[1] = '{1'b1, 3233, 17,   2753, 2790, 65};
      tv[2] = '{1'b0, 33,   3,    7,    4,    31};
      tv[3] = '{1'b1, 33,   3,    7,    31,   4};
      tv[4] = '{1'b0, 3233, 0,    0,    1234, 1};
      tv[5] = '{1'b0, 3233, 17,   0,    0,    0};
      tv[6] = '{1'b0, 3233, 2,    0,    3232, 1};

      bus.exe = 1'b0; bus.mode = 1'b0;
      bus.n_mod = 16'd3233; bus.e_key = 16'd17; bus.d_key = 16'd2753;
      for (int i = 0; i < NW; i++) mem[i] = '0;

      // reset state, before any clock edge
      #1 rst_n = 1'b0;
      #1 chk("reset_outputs", outs(), 0);
      @(negedge clk); #1 rst_n = 1'b1;

      // single-word vectors: result, capture, latency, strobe width
      foreach (tv[k]) begin
         do_reset();
         mem[0] = W'(tv[k].m);
         bus.mode = tv[k].mode;
         bus.n_mod = W'(tv[k].n); bus.e_key = W'(tv[k].e); bus.d_key = W'(tv[k].d);
         base = npulse;
         bus.exe = 1'b1;
         wait_pulses(base + 1, $sformatf("vec%0d_pulse", k));
         chk($sformatf("vec%0d_result", k), bus.result, tv[k].exp);
         chk($sformatf("vec%0d_busy", k), bus.busy, 1);
         if (cap_q.size() > 0) chk($sformatf("vec%0d_capture", k), cap_q[$], tv[k].exp);
         chk($sformatf("vec%0d_latency", k), last_lat,
             2 + W * (W + $countones(tv[k].mode ? tv[k].d : tv[k].e)));
         @(negedge clk); #1;
         chk($sformatf("vec%0d_oen_width", k), bus.o_en, 0);
         bus.exe = 1'b0;
      end

      // full stream, exe held high throughout
      do_reset();
      for (int i = 0; i < NW; i++) mem[i] = W'(i);
      bus.mode = 1'b0; bus.n_mod = 16'd3233; bus.e_key = 16'd17;
      cap_q.delete();
      base = npulse;
      bus.exe = 1'b1;
      wait_pulses(base + NW, "stream_pulses");
      for (int i = 0; i < NW; i++)
         if (i < cap_q.size()) chk($sformatf("stream_w%0d", i), cap_q[i], modexp(i, 17, 3233));
      repeat (2) @(negedge clk);
      #1;
      chk("stream_done", bus.done, 1);
      chk("stream_busy", bus.busy, 0);
      repeat (700) @(negedge clk);
      #1;
      chk("stream_no_rerun", npulse - base, NW);
      chk("stream_done_held", bus.done, 1);
      bus.exe = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk("done_clears", bus.done, 0);

      // mode flips during word 3; exe dropped mid-run
      do_reset();
      for (int i = 0; i < NW; i++) mem[i] = 16'd4;
      bus.mode = 1'b0; bus.n_mod = 16'd33; bus.e_key = 16'd3; bus.d_key = 16'd7;
      cap_q.delete();
      base = npulse;
      bus.exe = 1'b1;
      repeat (3) @(negedge clk);
      bus.exe = 1'b0;
      wait_pulses(base + 3, "mode_pulses3");
      wait_fetch("mode_fetch3");
      repeat (10) @(negedge clk);
      bus.mode = 1'b1;
      wait_pulses(base + 5, "mode_pulses5");
      for (int i = 0; i < 5; i++)
         if (i < cap_q.size()) chk($sformatf("mode_w%0d", i), cap_q[i], modexp(4, (i <= 3) ? 3 : 7, 33));

      // async reset during MUL of word 5, then random restart
      do_reset();
      for (int i = 0; i < NW; i++) mem[i] = W'($urandom_range(3232, 0));
      bus.mode = 1'b0; bus.n_mod = 16'd3233; bus.e_key = 16'd17;
      base = npulse;
      bus.exe = 1'b1;
      wait_pulses(base + 5, "arst_pulses");
      wait_fetch("arst_fetch5");
      repeat (200) @(negedge clk);
      #1 chk("arst_busy_before", bus.busy, 1);
      bus.exe = 1'b0;
      rst_n = 1'b0;
      #1 chk("arst_outputs", outs(), 0);
      @(negedge clk); #1 rst_n = 1'b1;

      n = $urandom_range(65535, 2);
      e = $urandom_range(65535, 0);
      d = $urandom_range(65535, 0);
      md = 1'($urandom_range(1, 0));
      for (int i = 0; i < NW; i++) mem[i] = W'($urandom_range(n - 1, 0));
      bus.mode = md; bus.n_mod = W'(n); bus.e_key = W'(e); bus.d_key = W'(d);
      cap_q.delete();
      base = npulse;
      bus.exe = 1'b1;
      wait_fetch("rand_first_fetch");
      chk("rand_first_addr", bus.mem_addr, 0);
      wait_pulses(base + NW, "rand_pulses");
      for (int i = 0; i < NW; i++)
         if (i < cap_q.size())
            chk($sformatf("rand_w%0d", i), cap_q[i], modexp(mem[i], md ? d : e, n));
      bus.exe = 1'b0;
      repeat (3) @(negedge clk);

      chk("oen_single_cycle", wide_err, 0);
      chk("result_hold", hold_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
